// File: rtl/two_phase_sequencer_if.sv
// rtl/two_phase_sequencer_if.sv - request/phase/status bundle between sequencer and its checker
interface two_phase_sequencer_if #(
    parameter int RND_W = 8
);
    logic             start;
    logic             stop;
    logic             s1;
    logic             phase1_prop;
    logic             s2;
    logic             phase2_prop;
    logic             busy;
    logic             done;
    logic [RND_W-1:0] round_cnt;

    modport master (
        input  start, stop,
        output s1, phase1_prop, s2, phase2_prop, busy, done, round_cnt
    );

    modport slave (
        output start, stop,
        input  s1, phase1_prop, s2, phase2_prop, busy, done, round_cnt
    );
endinterface

// File: rtl/two_phase_sequencer.sv
// rtl/two_phase_sequencer.sv - Moore sequencer alternating phase 1 / phase 2 windows per round
module two_phase_sequencer #(
    parameter int PHASE1_LEN = 4,
    parameter int PHASE2_LEN = 4,
    parameter int NUM_ROUNDS = 1,
    parameter int RND_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    two_phase_sequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;

    localparam logic [7:0]       PH1_LAST = 8'(PHASE1_LEN - 1);
    localparam logic [7:0]       PH2_LAST = 8'(PHASE2_LEN - 1);
    localparam logic [RND_W-1:0] ROUNDS   = RND_W'(NUM_ROUNDS);

    state_t           state;
    logic [7:0]       dwell;
    logic [RND_W-1:0] round_cnt;
    logic             stop_pend;
    logic             s1_q, p1_q, s2_q, p2_q, busy_q, done_q;

    logic [RND_W-1:0] rnd_inc;
    logic             finish_run;

    assign rnd_inc    = round_cnt + RND_W'(1);
    assign finish_run = stop_pend || bus.stop || ((NUM_ROUNDS != 0) && (rnd_inc == ROUNDS));

    // Outputs are registered with the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dwell     <= 8'd0;
            round_cnt <= '0;
            stop_pend <= 1'b0;
            s1_q      <= 1'b0;
            p1_q      <= 1'b0;
            s2_q      <= 1'b0;
            p2_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            s1_q   <= 1'b0;
            p1_q   <= 1'b0;
            s2_q   <= 1'b0;
            p2_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= PH1;
                        dwell     <= 8'd0;
                        round_cnt <= '0;
                        stop_pend <= 1'b0;
                        s1_q      <= 1'b1;
                        p1_q      <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                PH1: begin
                    busy_q <= 1'b1;
                    if (bus.stop) stop_pend <= 1'b1;
                    if (dwell == PH1_LAST) begin
                        state <= PH2;
                        dwell <= 8'd0;
                        s2_q  <= 1'b1;
                        p2_q  <= 1'b1;
                    end else begin
                        dwell <= dwell + 8'd1;
                        p1_q  <= 1'b1;
                    end
                end
                PH2: begin
                    if (bus.stop) stop_pend <= 1'b1;
                    if (dwell == PH2_LAST) begin
                        round_cnt <= rnd_inc;
                        dwell     <= 8'd0;
                        if (finish_run) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= PH1;
                            s1_q   <= 1'b1;
                            p1_q   <= 1'b1;
                            busy_q <= 1'b1;
                        end
                    end else begin
                        dwell  <= dwell + 8'd1;
                        p2_q   <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s1          = s1_q;
    assign bus.phase1_prop = p1_q;
    assign bus.s2          = s2_q;
    assign bus.phase2_prop = p2_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.round_cnt   = round_cnt;
endmodule

// File: doc/two_phase_sequencer.md
# two_phase_sequencer

Synthesizable Moore sequencer that drives a two-phase alternating protocol: after a start request it alternates phase 1 and phase 2 windows, each opened by a one-cycle strobe. It asserts a busy level until a one-cycle completion pulse. It is the driving end of the phase-alternation and weak-until assertion checks. Its outputs connect directly to the checker's s1/s2/phase*_prop/busy/done inputs.

## Interface
- PHASE1_LEN, default 4: phase 1 window length in cycles, legal range 1..255.
- PHASE2_LEN, default 4: phase 2 window length in cycles, legal range 1..255.
- NUM_ROUNDS, default 1: PH1+PH2 rounds per run. 0 means run until stop.
- RND_W, default 8: width of the round counter.
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  run request; honoured only in IDLE.
- stop  in  1  finish request; sampled in PH1/PH2 and latched.
- s1  out  1  phase 1 opening strobe.
- phase1_prop  out  1  phase 1 window level.
- s2  out  1  phase 2 opening strobe.
- phase2_prop  out  1  phase 2 window level.
- busy  out  1  run in progress.
- done  out  1  run complete, one-cycle pulse.
- round_cnt  out  RND_W  completed rounds in the current or last run.

## Operation
- States: IDLE, PH1, PH2, DONE. All outputs are decoded from registered state and counters. There is no combinational input-to-output path.
- Registers: state, dwell counter (8 bit), round_cnt, stop_pend.
- IDLE: outputs s1, s2, phase*_prop, busy and done are 0. If start=1, go to PH1, load dwell=0, clear round_cnt and stop_pend.
- PH1:
  - phase1_prop=1 and busy=1 every cycle.
  - s1=1 only when dwell==0.
  - At dwell==PHASE1_LEN-1, go to PH2 with dwell=0. Otherwise dwell increments.
- PH2:
  - phase2_prop=1 and busy=1 every cycle.
  - s2=1 only when dwell==0.
  - At dwell==PHASE2_LEN-1, round_cnt increments (wraps modulo 2^RND_W).
  - Then go to DONE if stop_pend, or stop on this cycle, or (NUM_ROUNDS!=0 and the incremented count==NUM_ROUNDS).
  - Otherwise go to PH1 with dwell=0.
- DONE: done=1, busy=0, all phase outputs 0. Go to IDLE unconditionally.
- stop=1 in any PH1/PH2 cycle sets stop_pend. The current round always completes; a stop never truncates a phase.
- In IDLE and DONE, stop is ignored.
- start while in PH1, PH2 or DONE is ignored and not queued.
- start and stop both high in IDLE: start is honoured, stop is ignored.
- round_cnt holds its value through DONE and IDLE until the next accepted start.
- Guaranteed invariants:
  - s1 implies phase1_prop; s2 implies phase2_prop.
  - The cycle after an s1 window cycle is never a PH2 cycle with phase2_prop=0. The same holds symmetrically for s2 and phase 1.
  - phase1_prop and phase2_prop are never both 1.
  - After start is accepted, busy stays 1 every cycle until the cycle where done=1.
- Reset (rst_n=0 at a rising edge), including mid-run: state=IDLE, dwell=0, round_cnt=0, stop_pend=0. All outputs read 0 on the following cycle. No done pulse is produced for the aborted run.

## Timing
- Cycle numbering: start is accepted at the edge ending cycle 0.
- PH1 occupies cycles 1..L1, with s1 at cycle 1.
- PH2 occupies cycles L1+1..L1+L2, with s2 at cycle L1+1.
- Round r (0-based) begins at cycle 1 + r·(L1+L2).
- done is high at cycle 1 + N·(L1+L2); IDLE resumes the cycle after.
- Minimum start-to-start spacing: N·(L1+L2)+2 cycles.
- With L1=L2=1: s1/phase1_prop and s2/phase2_prop alternate every cycle, and s1 and s2 are each high for the full phase.
- stop latency: a stop in round r ends the run after round r's PH2. done follows that PH2's last cycle by one cycle.

## Test plan
- Defaults (4,4,1):
  - start pulse at cycle 0 gives s1@1, phase1_prop@1..4, s2@5, phase2_prop@5..8, done@9, busy@1..8.
  - round_cnt=1 from cycle 9; IDLE at 10.
- NUM_ROUNDS=3, L1=2, L2=3: s1 at cycles 1, 6 and 11; s2 at cycles 3, 8 and 13; done@16; round_cnt=3.
- NUM_ROUNDS=0, defaults, stop pulsed at cycle 10 (round 1, PH1): run finishes after PH2 of round 1, giving done@17 and round_cnt=2. A stop issued in IDLE afterwards has no effect.
- L1=L2=1, NUM_ROUNDS=4: outputs alternate s1/s2 cycles 1..8 and done@9. A concurrent assertion monitor (phase alternation, weak-until busy/done) reports zero failures.
- Extra start pulses at cycles 3 and 9 (DONE) of a default run are ignored: no second run, busy=0 at cycle 10.
- rst_n low at cycle 6 (mid-PH2) gives all outputs 0 at cycle 7, no done pulse and round_cnt=0. A new start at cycle 8 gives s1@9.
